// File: rtl/gray_conv_sched_pkg.sv
// Shared types and helpers for the gray_conv_sched scheduler.
// The conversion helper works on a wide word; callers size the argument and result to their W.
package gray_pkg;

    localparam int W_DEF  = 4;
    localparam int N_DEF  = 4;
    localparam int GW_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        B2G  = 2'd1,
        G2B  = 2'd2,
        RESP = 2'd3
    } state_t;

    // Zero-extended inputs give g[W-1] = b[W-1] at any W up to GW_MAX.
    function automatic logic [GW_MAX-1:0] bin2gray(input logic [GW_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_conv_sched_if.sv
// Request/response bundle between requesters, the scheduler and the result consumer.
interface gray_conv_sched_if #(
    parameter int W = gray_pkg::W_DEF,
    parameter int N = gray_pkg::N_DEF
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_mode;
    logic           resp_valid;
    logic           resp_ready;
    logic [W-1:0]   resp_data;
    logic [IDW-1:0] resp_id;
    logic           resp_mode;

    modport master (
        output req_valid, req_data, req_mode, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_id, resp_mode
    );

    modport slave (
        input  req_valid, req_data, req_mode, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id, resp_mode
    );

endinterface

// File: rtl/gray_conv_sched_rr_arb.sv
// Round-robin arbiter: first valid requester searching upward from last_id+1 (mod N).
module gray_rr_arb #(
    parameter int N = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_valid,
    input  logic [IDW-1:0] last_id,
    input  logic           enable,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] gnt_id
);

    // Rotating priority search; the first hit latches and blocks later candidates.
    always_comb begin
        logic found;
        grant  = {N{1'b0}};
        gnt_id = {IDW{1'b0}};
        found  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int  idx;
            logic hit;
            idx = int'(last_id) + k;
            idx = (idx >= N) ? (idx - N) : idx;
            hit = enable & ~found & req_valid[idx];
            grant[idx] = hit;
            gnt_id = hit ? IDW'(idx) : gnt_id;
            found  = found | hit;
        end
    end

endmodule

// File: rtl/gray_conv_sched.sv
// Scheduler top: arbitration, FSM, serial Gray->binary bit counter and held response register.
module gray_conv_sched
    import gray_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    gray_conv_sched_if.slave   bus,
    output logic               busy
);

    localparam int IDW = $clog2(N);
    localparam int CW  = $clog2(W);

    state_t          state_r, state_s;
    logic [IDW-1:0]  last_id_r;
    logic [W-1:0]    data_r;
    logic            mode_r;
    logic [IDW-1:0]  id_r;
    logic [CW-1:0]   cnt_r;
    logic [W-1:0]    res_r, res_s;
    logic            prev_s, bit_s;
    logic [W-1:0]    gray_s;
    logic            resp_valid_r, resp_mode_r, busy_r;
    logic [W-1:0]    resp_data_r;
    logic [IDW-1:0]  resp_id_r;
    logic [N-1:0]    grant_s;
    logic [IDW-1:0]  gnt_id_s;
    logic            arb_en_s, xfer_s, sel_mode_s;
    logic [W-1:0]    sel_data_s;

    // Grants are suppressed while reset is asserted so req_ready reads 0 immediately.
    assign arb_en_s = (state_r == IDLE) & rst_n;

    gray_rr_arb #(.N(N)) u_arb (
        .req_valid (bus.req_valid),
        .last_id   (last_id_r),
        .enable    (arb_en_s),
        .grant     (grant_s),
        .gnt_id    (gnt_id_s)
    );

    assign bus.req_ready  = grant_s;
    assign xfer_s         = |(bus.req_valid & grant_s);
    assign sel_mode_s     = bus.req_mode[gnt_id_s];
    assign sel_data_s     = bus.req_data[int'(gnt_id_s)*W +: W];
    assign gray_s         = W'(bin2gray(GW_MAX'(data_r)));

    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_data  = resp_data_r;
    assign bus.resp_id    = resp_id_r;
    assign bus.resp_mode  = resp_mode_r;
    assign busy           = busy_r;

    // One Gray->binary bit per cycle, MSB first, reusing the bit above from res_r.
    always_comb begin
        res_s  = res_r;
        prev_s = 1'b0;
        if (cnt_r == CW'(W-1)) begin
            prev_s = 1'b0;
        end else begin
            prev_s = res_r[cnt_r + CW'(1)];
        end
        bit_s        = prev_s ^ data_r[cnt_r];
        res_s[cnt_r] = bit_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (xfer_s) begin
                    state_s = sel_mode_s ? G2B : B2G;
                end else begin
                    state_s = IDLE;
                end
            end
            B2G: state_s = RESP;
            G2B: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = RESP;
                end else begin
                    state_s = G2B;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            resp_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            busy_r       <= (state_s != IDLE);
            resp_valid_r <= (state_s == RESP);
        end
    end

    // Job capture, conversion datapath, response hold and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id_r   <= IDW'(N-1);
            data_r      <= {W{1'b0}};
            mode_r      <= 1'b0;
            id_r        <= {IDW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            res_r       <= {W{1'b0}};
            resp_data_r <= {W{1'b0}};
            resp_id_r   <= {IDW{1'b0}};
            resp_mode_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (xfer_s) begin
                        data_r <= sel_data_s;
                        mode_r <= sel_mode_s;
                        id_r   <= gnt_id_s;
                        cnt_r  <= CW'(W-1);
                        res_r  <= {W{1'b0}};
                    end else begin
                        cnt_r  <= cnt_r;
                    end
                end
                B2G: begin
                    resp_data_r <= gray_s;
                    resp_id_r   <= id_r;
                    resp_mode_r <= mode_r;
                end
                G2B: begin
                    res_r <= res_s;
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == {CW{1'b0}}) begin
                        resp_data_r <= res_s;
                        resp_id_r   <= id_r;
                        resp_mode_r <= mode_r;
                    end else begin
                        resp_data_r <= resp_data_r;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        last_id_r <= resp_id_r;
                    end else begin
                        last_id_r <= last_id_r;
                    end
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule
